// File: rtl/ram_ctrl_pkg.sv
// Shared state type, default sizing and helpers for the RAM request controller.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_RSP_DEPTH = 4;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_e;

  // Counter wide enough to hold every value from 0 to depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Synchronous show-ahead FIFO with a registered head output, used for RAM read responses.
module ram_rsp_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // dout always mirrors the oldest entry, so the next head is preloaded on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (empty) begin
        if (do_push) begin
          dout <= din;
        end
      end else if (do_pop) begin
        if (count > CNT_W'(1)) begin
          dout <= mem[ptr_inc(rd_ptr)];
        end else if (do_push) begin
          dout <= din;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request-side controller for a single-port RAM: init sweep after reset, then
// valid/ready requests mapped onto RAM cycles with reads returned through a FIFO.
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                RSP_DEPTH  = DEF_RSP_DEPTH,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              init_done_o
);

  localparam int              CNT_W      = cnt_width(RSP_DEPTH);
  localparam int              CRED_W     = CNT_W + 1;
  localparam logic [ADDR_W:0] SWEEP_LAST = {1'b0, {ADDR_W{1'b1}}};

  ctrl_state_e       state;
  ctrl_state_e       next_state;
  logic [ADDR_W:0]   sweep_cnt;
  logic              rd_pending;
  logic              init_done;
  logic              fire;
  logic              rsp_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CRED_W-1:0] credits_used;

  // A read holds a credit from fire until it is popped, so the FIFO can never overflow.
  assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending};
  assign req_ready_o  = !rst_i && (state == RUN) && (credits_used < CRED_W'(RSP_DEPTH));
  assign fire         = req_valid_i && req_ready_o;
  assign rsp_valid_o  = !fifo_empty;
  assign rsp_pop      = rsp_valid_o && rsp_ready_i;
  assign init_done_o  = init_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      rd_pending <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state      <= next_state;
      if (state == INIT) begin
        sweep_cnt <= sweep_cnt + (ADDR_W+1)'(1);
      end
      rd_pending <= fire && !req_we_i;
      init_done  <= (next_state == RUN);
    end
  end

  // RUN is a pure pass-through; idle RUN cycles become harmless reads.
  always_comb begin
    next_state = state;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    case (state)
      INIT: begin
        ram_we_o   = 1'b1;
        ram_addr_o = sweep_cnt[ADDR_W-1:0];
        ram_data_o = INIT_VALUE;
        if (sweep_cnt == SWEEP_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        ram_addr_o = req_addr_i;
        ram_data_o = req_wdata_i;
        ram_we_o   = fire && req_we_i;
      end
      default: next_state = INIT;
    endcase
    if (rst_i) begin
      ram_we_o   = 1'b0;
      ram_addr_o = '0;
      ram_data_o = '0;
    end
  end

  ram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (rd_pending),
    .pop   (rsp_pop),
    .din   (ram_rdata_i),
    .dout  (rsp_rdata_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rd_pending && fifo_full));

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Scoreboard bench for ram_req_ctrl driving a behavioural 256x32 registered-read RAM.
module tb_ram_req_ctrl;

  localparam int WORDS = 256;

  logic        clk_i       = 1'b0;
  logic        rst_i       = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_we_i    = 1'b0;
  logic [7:0]  req_addr_i  = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_ready_i = 1'b1;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [7:0]  ram_addr_o;
  logic [31:0] ram_data_o;
  logic        ram_we_o;
  logic [31:0] ram_rdata_i;
  logic        init_done_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  ram_req_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_we_o    (ram_we_o),
    .ram_rdata_i (ram_rdata_i),
    .init_done_o (init_done_o)
  );

  // RAM starts with garbage so that only the init sweep can make it read as zero.
  logic [31:0] ram_mem [WORDS];
  bit          ram_seeded;
  always @(posedge clk_i) begin
    if (!ram_seeded) begin
      for (int i = 0; i < WORDS; i++) ram_mem[i] <= $urandom;
      ram_seeded <= 1'b1;
    end else if (ram_we_o) begin
      ram_mem[ram_addr_o] <= ram_data_o;
    end else begin
      ram_rdata_i <= ram_mem[ram_addr_o];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: memory as seen by requests, plus expected responses in order.
  logic [31:0] model_mem [WORDS];
  logic [31:0] exp_data_q [$];
  int          exp_cyc_q [$];
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_data_q.delete();
      exp_cyc_q.delete();
      for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
    end else if (req_valid_i && req_ready_o) begin
      if (req_we_i) begin
        model_mem[req_addr_i] = req_wdata_i;
      end else begin
        exp_data_q.push_back(model_mem[req_addr_i]);
        exp_cyc_q.push_back(cyc);
      end
    end
  end

  int          rsp_count  = 0;
  int          last_lat   = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  always @(negedge clk_i) begin
    if (prev_stall) begin
      checkOutput("rsp_hold_valid", rsp_valid_o, 1);
      checkOutput("rsp_hold_data", rsp_rdata_o, prev_data);
    end
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (exp_data_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL rsp_unexpected: got 0x%08h, expected no response", rsp_rdata_o);
      end else begin
        logic [31:0] exp_d;
        int          fire_cyc;
        exp_d    = exp_data_q.pop_front();
        fire_cyc = exp_cyc_q.pop_front();
        last_lat = cyc - fire_cyc;
        checkOutput("rsp_data", rsp_rdata_o, exp_d);
        checkOutput("rsp_latency_min", (last_lat >= 2), 1);
      end
      rsp_count++;
    end
    prev_stall = !rst_i && rsp_valid_o && !rsp_ready_i;
    prev_data  = rsp_rdata_o;
  end

  int sweep_writes   = 0;
  int sweep_bad_data = 0;
  int sweep_ready_hi = 0;
  bit sweep_seen [WORDS];
  always @(negedge clk_i) begin
    if (rst_i) begin
      sweep_writes   = 0;
      sweep_bad_data = 0;
      sweep_ready_hi = 0;
      for (int i = 0; i < WORDS; i++) sweep_seen[i] = 1'b0;
    end else if (!init_done_o) begin
      if (ram_we_o) begin
        sweep_writes++;
        sweep_seen[ram_addr_o] = 1'b1;
        if (ram_data_o != 32'h0) sweep_bad_data++;
      end
      if (req_ready_o) sweep_ready_hi++;
    end
  end

  // Called just after rst_i deasserts; counts cycles spent before init_done_o.
  task automatic checkInitSweep(input string tag);
    int n = 0;
    int covered = 0;
    @(negedge clk_i);
    while (!init_done_o && n < 1000) begin
      n++;
      @(negedge clk_i);
    end
    for (int i = 0; i < WORDS; i++) covered += int'(sweep_seen[i]);
    checkOutput({tag, "_init_cycles"}, n, 256);
    checkOutput({tag, "_sweep_writes"}, sweep_writes, 256);
    checkOutput({tag, "_sweep_coverage"}, covered, 256);
    checkOutput({tag, "_sweep_data"}, sweep_bad_data, 0);
    checkOutput({tag, "_ready_in_init"}, sweep_ready_hi, 0);
    @(posedge clk_i); #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [31:0] data);
    int waited = 0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = data;
    @(negedge clk_i);
    while (!req_ready_o && waited < 200) begin
      waited++;
      @(negedge clk_i);
    end
    if (!req_ready_o) begin
      tests++;
      fails++;
      $display("[TB] FAIL req_accept_timeout: ready=%0d after %0d cycles, expected 1", req_ready_o, waited);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic waitResponses(input string name, input int target);
    int k = 0;
    while (rsp_count < target && k < 200) begin
      k++;
      @(negedge clk_i);
    end
    checkOutput(name, rsp_count, target);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    int idx;
    int stalls;
    int reads;

    repeat (3) @(negedge clk_i);
    checkOutput("rst_ram_we", ram_we_o, 0);
    checkOutput("rst_ram_addr", ram_addr_o, 0);
    checkOutput("rst_ram_data", ram_data_o, 0);
    checkOutput("rst_req_ready", req_ready_o, 0);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata_o, 0);
    checkOutput("rst_init_done", init_done_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checkInitSweep("boot");

    base = rsp_count;
    applyStimulus(1'b1, 8'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 8'h10, 32'h0);
    waitResponses("raw_rsp_count", base + 1);
    checkOutput("raw_latency", last_lat, 2);

    applyStimulus(1'b0, 8'h55, 32'h0);
    waitResponses("unwritten_rsp_count", base + 2);
    checkOutput("unwritten_latency", last_lat, 2);

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(i), 32'h100 + 32'(i));
    base = rsp_count;
    rsp_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid_i = (idx < 6);
      req_we_i    = 1'b0;
      req_addr_i  = 8'(idx);
      @(negedge clk_i);
      if (req_valid_i && req_ready_o) idx++;
      @(posedge clk_i); #1;
    end
    checkOutput("bp_accepted", idx, 4);
    @(negedge clk_i);
    checkOutput("bp_ready_low", req_ready_o, 0);
    checkOutput("bp_rsp_valid", rsp_valid_o, 1);
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 50 && idx < 6; c++) begin
      req_valid_i = 1'b1;
      req_addr_i  = 8'(idx);
      @(negedge clk_i);
      if (req_ready_o) idx++;
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    checkOutput("bp_all_accepted", idx, 6);
    waitResponses("bp_rsp_count", base + 6);

    base   = rsp_count;
    stalls = 0;
    reads  = 0;
    for (int c = 0; c < 200; c++) begin
      req_valid_i = 1'b1;
      req_we_i    = 1'($urandom_range(0, 1));
      req_addr_i  = 8'($urandom_range(0, 15));
      req_wdata_i = $urandom;
      @(negedge clk_i);
      if (!req_ready_o) stalls++;
      else if (!req_we_i) reads++;
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    checkOutput("stream_stalls", stalls, 0);
    waitResponses("stream_rsp_count", base + reads);

    for (int c = 0; c < 300; c++) begin
      req_valid_i = 1'($urandom_range(0, 1));
      req_we_i    = 1'($urandom_range(0, 1));
      req_addr_i  = 8'($urandom_range(0, 31));
      req_wdata_i = $urandom;
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    n = 0;
    while (exp_data_q.size() != 0 && n < 200) begin
      n++;
      @(posedge clk_i); #1;
    end
    checkOutput("random_drain", exp_data_q.size(), 0);

    applyStimulus(1'b1, 8'h10, 32'hCAFEF00D);
    rsp_ready_i = 1'b0;
    applyStimulus(1'b0, 8'h10, 32'h0);
    applyStimulus(1'b0, 8'h10, 32'h0);
    base  = rsp_count;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("midrst_rsp_valid", rsp_valid_o, 0);
    checkOutput("midrst_init_done", init_done_o, 0);
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    rsp_ready_i = 1'b1;
    checkInitSweep("rerun");
    checkOutput("midrst_no_rsp", rsp_count, base);

    applyStimulus(1'b0, 8'h10, 32'h0);
    waitResponses("post_rst_rsp_count", base + 1);
    checkOutput("post_rst_latency", last_lat, 2);

    repeat (3) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
